// File: rtl/vga_fetch_pkg.sv
// vga_fetch_pkg: shared constants and FSM encoding for the VGA frame fetcher.
package vga_fetch_pkg;
    localparam int ADDR_W = 26;
    localparam int DEF_BURST_LEN = 8;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
endpackage

// File: rtl/vga_fetch_if.sv
// vga_fetch_if: burst-read bus between the fetcher (master) and the SDRAM arbiter (slave).
// Signals: vga_request/vga_address (burst request), vga_rdata/vga_valid (returned words),
// vga_complete (transaction done pulse).
interface vga_fetch_if;
    import vga_fetch_pkg::*;
    logic vga_request;
    logic [ADDR_W-1:0] vga_address;
    logic [31:0] vga_rdata;
    logic vga_valid;
    logic vga_complete;
    modport master (output vga_request, vga_address, input vga_rdata, vga_valid, vga_complete);
    modport slave (input vga_request, vga_address, output vga_rdata, vga_valid, vga_complete);
endinterface

// File: rtl/vga_line_fifo.sv
// vga_line_fifo: synchronous first-word-fall-through FIFO with flush.
// Ports: clock, reset (sync, active-low), flush (empties FIFO, wins over push/pop),
// push/wdata, pop (ignored when empty), rdata (head word), valid (not empty), count.
module vga_line_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_pop;
    assign do_pop = pop && count != '0;
    assign valid = count != '0;
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata;
    end
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/vga_fetch.sv
// vga_fetch: fetches frame-buffer words in SDRAM bursts into a pixel FIFO.
// Ports: clock, reset (sync, active-low), frame_base/frame_words (frame geometry),
// enable (allow new bursts), frame_start (vsync restart), bus (arbiter master port),
// pix_data/pix_valid/pix_ready (FWFT pixel stream), underflow (sticky empty-pop flag).
module vga_fetch
    import vga_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  frame_base,
    input  logic [19:0]        frame_words,
    input  logic               enable,
    input  logic               frame_start,
    vga_fetch_if.master        bus,
    output logic [31:0]        pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               underflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN * 4);
    state_t state, next;
    logic [ADDR_W-1:0] addr;
    logic [19:0] remaining;
    logic [CW-1:0] count;
    logic req_q, discard, restart, flush, go, push, pop;

    // A restart (immediate or deferred from mid-burst) is only applied in IDLE.
    assign flush = state == IDLE && (frame_start || restart);
    // Nothing is in flight while IDLE (DRAIN catches the last word), so free space is just DEPTH - count.
    assign go = enable && remaining != '0 && !restart && !frame_start
                && 32'(count) + 32'(BURST_LEN) <= 32'(FIFO_DEPTH);
    assign push = bus.vga_valid && state != IDLE && !discard && !frame_start;
    assign pop = pix_valid && pix_ready;
    assign bus.vga_request = req_q;
    assign bus.vga_address = addr;

    always_comb begin
        next = state;
        if (state == IDLE && go) next = REQ;
        else if (state == REQ && bus.vga_complete) next = DRAIN;
        else if (state == DRAIN) next = IDLE;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            req_q <= 1'b0;
            addr <= '0;
            remaining <= '0;
            discard <= 1'b0;
            restart <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state <= next;
            req_q <= next == REQ;
            if (flush) begin
                addr <= frame_base & ~ADDR_W'(31);
                remaining <= frame_words;
                discard <= 1'b0;
                restart <= 1'b0;
            end else begin
                if (state == REQ && bus.vga_complete) begin
                    addr <= addr + ADDR_STEP;
                    remaining <= remaining - 20'(BURST_LEN);
                end
                // Here frame_start can only arrive mid-burst: let the burst finish but drop its data.
                if (frame_start) begin
                    discard <= 1'b1;
                    restart <= 1'b1;
                end
            end
            underflow <= !flush && (underflow || (pix_ready && !pix_valid));
        end
    end

    vga_line_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .push(push),
        .wdata(bus.vga_rdata),
        .pop(pop),
        .rdata(pix_data),
        .valid(pix_valid),
        .count(count)
    );
endmodule

// File: tb/tb_vga_fetch.sv
// tb_vga_fetch: directed sequence with random data and addresses, checked against a queue model.
module tb_vga_fetch;
    localparam int DEPTH = 64;
    localparam int BL = 8;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [25:0] frame_base = '0;
    logic [19:0] frame_words = '0;
    logic enable = 1'b0;
    logic frame_start = 1'b0;
    logic pix_ready = 1'b0;
    logic [31:0] pix_data;
    logic pix_valid, underflow;
    int checks = 0;
    int errors = 0;
    logic ovf = 1'b0;
    int unsigned exp_q[$];

    vga_fetch_if bus();

    vga_fetch #(.FIFO_DEPTH(DEPTH), .BURST_LEN(BL)) dut (
        .clock(clock),
        .reset(reset),
        .frame_base(frame_base),
        .frame_words(frame_words),
        .enable(enable),
        .frame_start(frame_start),
        .bus(bus),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .underflow(underflow)
    );

    always #5 clock = ~clock;

    always @(negedge clock)
        if (reset && dut.push && 32'(dut.count) == DEPTH) ovf <= 1'b1;

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            if (bus.vga_request === 1'b1) found = 1'b1;
            else tick();
        end
    endtask

    task automatic pulse_start;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        exp_q.delete();
    endtask

    // Arbiter model: words 0..BL-2 with random gaps, complete with word BL-2, last word one cycle later.
    task automatic serve_burst(input string tag, input logic [25:0] exp_addr, input int fs_at, input int en_off_at);
        bit ok;
        bit drop;
        ok = 1'b1;
        drop = 1'b0;
        check({tag, "_addr"}, 64'(bus.vga_address), 64'(exp_addr));
        for (int k = 0; k < BL - 1; k++) begin
            repeat ($urandom_range(0, 1)) begin
                ok = ok && bus.vga_request === 1'b1 && bus.vga_address === exp_addr;
                tick();
            end
            ok = ok && bus.vga_request === 1'b1 && bus.vga_address === exp_addr;
            bus.vga_rdata = $urandom;
            bus.vga_valid = 1'b1;
            bus.vga_complete = k == BL - 2;
            if (k == fs_at) begin
                frame_start = 1'b1;
                drop = 1'b1;
                exp_q.delete();
            end
            if (k == en_off_at) enable = 1'b0;
            if (!drop) exp_q.push_back(bus.vga_rdata);
            tick();
            frame_start = 1'b0;
            bus.vga_valid = 1'b0;
            bus.vga_complete = 1'b0;
        end
        check({tag, "_held"}, 64'(ok), 64'(1));
        check({tag, "_req_drop"}, 64'(bus.vga_request), 64'(0));
        bus.vga_rdata = $urandom;
        bus.vga_valid = 1'b1;
        if (!drop) exp_q.push_back(bus.vga_rdata);
        tick();
        bus.vga_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input int n);
        logic [32:0] got, exp, e;
        got = '0;
        exp = '0;
        for (int i = 0; i < n; i++) begin
            e = exp_q.size() != 0 ? {1'b1, exp_q.pop_front()} : 33'h0deadbeef;
            if ({pix_valid, pix_data} !== e && got === exp) begin
                got = {pix_valid, pix_data};
                exp = e;
            end
            pix_ready = 1'b1;
            tick();
        end
        pix_ready = 1'b0;
        check(tag, 64'(got), 64'(exp));
    endtask

    initial begin
        bit found;
        bit seen;
        int nb;
        logic [25:0] base_a;
        bus.vga_rdata = '0;
        bus.vga_valid = 1'b0;
        bus.vga_complete = 1'b0;
        tick();
        tick();
        check("rst_req", 64'(bus.vga_request), 64'(0));
        check("rst_addr", 64'(bus.vga_address), 64'(0));
        check("rst_pix_valid", 64'(pix_valid), 64'(0));
        check("rst_underflow", 64'(underflow), 64'(0));
        reset = 1'b1;
        enable = 1'b1;
        frame_base = 26'h0000100;
        frame_words = 20'd16;
        seen = 1'b0;
        repeat (6) begin
            seen = seen | bus.vga_request;
            tick();
        end
        check("no_fetch_before_start", 64'(seen), 64'(0));

        pulse_start();
        check("lat_flush_cycle", 64'(bus.vga_request), 64'(0));
        tick();
        check("lat_req", 64'(bus.vga_request), 64'(1));
        serve_burst("a0", 26'h0000100, -1, -1);
        check("a_count_after_drain", 64'(dut.count), 64'(8));
        wait_req(20, found);
        check("a1_seen", 64'(found), 64'(1));
        serve_burst("a1", 26'h0000120, -1, -1);
        bus.vga_rdata = $urandom;
        bus.vga_valid = 1'b1;
        tick();
        bus.vga_valid = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            seen = seen | bus.vga_request;
            tick();
        end
        check("a_stop_at_zero_remaining", 64'(seen), 64'(0));
        pop_check("a_data", 16);
        check("a_empty", 64'(pix_valid), 64'(0));

        pix_ready = 1'b1;
        tick();
        pix_ready = 1'b0;
        check("uf_set", 64'(underflow), 64'(1));
        repeat (3) tick();
        check("uf_hold", 64'(underflow), 64'(1));
        enable = 1'b0;
        frame_base = 26'($urandom);
        frame_words = 20'd64;
        base_a = frame_base & ~26'd31;
        pulse_start();
        check("uf_clear", 64'(underflow), 64'(0));
        seen = 1'b0;
        repeat (5) begin
            seen = seen | bus.vga_request;
            tick();
        end
        check("en0_block", 64'(seen), 64'(0));

        enable = 1'b1;
        wait_req(20, found);
        check("c0_seen", 64'(found), 64'(1));
        serve_burst("c0", base_a, 3, -1);
        wait_req(20, found);
        check("c1_seen", 64'(found), 64'(1));
        check("c_empty_before_req", 64'(pix_valid), 64'(0));
        serve_burst("c1", base_a, -1, -1);
        enable = 1'b0;
        pop_check("c_data", 8);

        frame_base = 26'($urandom);
        frame_words = 20'd256;
        base_a = frame_base & ~26'd31;
        enable = 1'b1;
        pulse_start();
        nb = 0;
        for (int i = 0; i < 9; i++) begin
            wait_req(30, found);
            if (!found) break;
            serve_burst("d", 26'(base_a + 26'(32 * nb)), -1, -1);
            nb++;
        end
        check("d_bursts", 64'(nb), 64'(8));
        check("d_count_full", 64'(dut.count), 64'(64));
        pop_check("d_pop8", 8);
        wait_req(30, found);
        check("d_refill_seen", 64'(found), 64'(1));
        serve_burst("d8", 26'(base_a + 26'(32 * 8)), -1, -1);
        wait_req(30, found);
        check("d_one_refill_only", 64'(found), 64'(0));
        pop_check("d_rest", 64);

        wait_req(30, found);
        check("e_seen", 64'(found), 64'(1));
        serve_burst("e", 26'(base_a + 26'(32 * 9)), -1, 3);
        seen = 1'b0;
        repeat (20) begin
            seen = seen | bus.vga_request;
            tick();
        end
        check("e_block", 64'(seen), 64'(0));
        pop_check("e_data", 8);
        enable = 1'b1;
        wait_req(20, found);
        check("e_resume", 64'(found), 64'(1));
        check("e_resume_addr", 64'(bus.vga_address), 64'(26'(base_a + 26'(32 * 10))));

        for (int k = 0; k < 3; k++) begin
            bus.vga_rdata = $urandom;
            bus.vga_valid = 1'b1;
            tick();
        end
        bus.vga_valid = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        tick();
        check("rst_mid_req", 64'(bus.vga_request), 64'(0));
        check("rst_mid_pix_valid", 64'(pix_valid), 64'(0));
        reset = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            seen = seen | bus.vga_request;
            tick();
        end
        check("rst_no_fetch", 64'(seen), 64'(0));
        check("no_overflow", 64'(ovf), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_fetch.md
VGA_FETCH -- requirements
Module: vga_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64, pixel-word FIFO depth in 32-bit words (power of 2, >= 2*BURST_LEN).
REQ-002 SHALL have parameter BURST_LEN, default 8, words per SDRAM burst read.
REQ-003 SHALL have ports:
  clock  in  1  sole clock; all logic on rising edge
  reset  in  1  synchronous, active-low (0 = reset)
  frame_base  in  26  frame buffer byte address; bits [4:0] ignored (forced 0)
  frame_words  in  20  32-bit words per frame; multiple of BURST_LEN
  enable  in  1  1 = fetching allowed
  frame_start  in  1  one-cycle pulse (vsync); restarts fetch at frame_base
  vga_request  out  1  burst read request to arbiter
  vga_address  out  26  burst start byte address
  vga_rdata  in  32  read data from arbiter
  vga_valid  in  1  one pulse per returned word
  vga_complete  in  1  transaction complete pulse
  pix_data  out  32  FIFO head word (first-word-fall-through)
  pix_valid  out  1  FIFO not empty
  pix_ready  in  1  consumer pops head when pix_valid=1
  underflow  out  1  sticky: pop attempted while empty

Function
REQ-004 SHALL implement FSM states IDLE, REQ, DRAIN.
REQ-005 IDLE -> REQ when enable=1, remaining>0, no restart pending, and (FIFO_DEPTH - count - in_flight) >= BURST_LEN; vga_request registered, asserted the cycle after transition.
REQ-006 In REQ, vga_request and vga_address SHALL be held stable until vga_complete is seen.
REQ-007 On vga_complete in REQ: vga_request SHALL be 0 on the next cycle; state -> DRAIN; address += BURST_LEN*4 (26-bit wrap); remaining -= BURST_LEN.
REQ-008 DRAIN SHALL last exactly one cycle (captures final word arriving one cycle after complete), then -> IDLE.
REQ-009 Every vga_valid in REQ or DRAIN SHALL push vga_rdata into the FIFO unless the burst is marked discard.
REQ-010 vga_valid in IDLE SHALL be ignored.
REQ-011 Pop occurs when pix_valid & pix_ready; simultaneous push and pop SHALL leave count unchanged and both take effect.
REQ-012 pix_ready with FIFO empty SHALL set underflow (cleared only by frame_start or reset); FIFO state unchanged.
REQ-013 FIFO overflow SHALL be impossible by construction of REQ-005; push-when-full is a design error (bench assertion).
REQ-014 frame_start in IDLE SHALL, next cycle: flush FIFO (count=0), address=frame_base, remaining=frame_words, underflow=0.
REQ-015 frame_start in REQ/DRAIN SHALL mark current burst discard and set restart pending; the burst completes normally (never aborted), its words dropped; restart per REQ-014 applied on return to IDLE.
REQ-016 frame_start coincident with pop SHALL give flush priority.
REQ-017 enable=0 SHALL block new requests only; an in-progress burst completes; FIFO contents retained.
REQ-018 remaining=0 SHALL stop requests until next frame_start; FIFO continues to drain.
REQ-019 Latency: first vga_request 2 cycles after frame_start in IDLE (flush cycle, then request).

Reset
REQ-020 While reset=0: state IDLE, vga_request=0, vga_address=0, remaining=0, FIFO empty, pix_valid=0, underflow=0, discard/restart flags clear.
REQ-021 Reset mid-burst SHALL drop the burst immediately; arbiter reset is common, so no handshake is owed.
REQ-022 No fetch SHALL occur after reset until first frame_start.

Structure
REQ-023 Shared package SHALL hold BURST_LEN default, 26-bit address width constant, and FSM state encoding.
REQ-024 FIFO SHALL be a sub-module vga_line_fifo (synchronous, FWFT, depth/width parameters, count output, flush input).

Verification
REQ-025 Reset, frame_base=0x0000100, frame_words=16, frame_start -> two bursts at 0x0000100, 0x0000120; 16 words in order; then request stays 0.
REQ-026 Final word delivered one cycle after vga_complete -> captured; FIFO count=8 after DRAIN.
REQ-027 pix_ready held 0, frame_words=256 -> requests stop at count=64 (8 bursts); one pop of 8 words -> exactly one new request.
REQ-028 frame_start mid-burst at word 3 -> burst completes, 0 of its words enter FIFO; next request at frame_base, FIFO empty before it.
REQ-029 pix_ready=1 with FIFO empty -> underflow=1, held until frame_start, then 0.
REQ-030 enable dropped mid-burst -> burst completes with all 8 words stored; no further request until enable=1.
